// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: pipelined Brent-Kung prefix adder/subtractor with valid/ready
// handshakes on both sides.
//
// Parameters:
//   WIDTH      operand/sum width in bits (>= 2)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; flushes every in-flight beat
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (combinational from out_valid/out_ready)
//   X, Y       operands
//   cin        carry-in (add) or borrow-in (sub)
//   sub        0: S = X + Y + cin, 1: S = X - Y - cin
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   S          sum/difference mod 2^WIDTH
//   cout       carry-out (NOT-borrow in sub mode)
//   ovf        two's-complement signed overflow
//   zero       S == 0
//
// Pipeline: R1 (X, Yeff, ceff) -> bitwise g/p/h + up-sweep -> R2 (h, up-sweep g/p)
// -> down-sweep + sum -> R3 (S, cout, ovf, zero). All stages advance together
// whenever the output register is empty or being drained.
module bk_adder_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned LVL = $clog2(WIDTH);

    logic adv;

    // R1
    logic             v1;
    logic [WIDTH-1:0] x1, y1;
    logic             c1;
    // R2
    logic             v2;
    logic [WIDTH-1:0] h2, g2, p2;
    logic             c2;
    // R3
    logic             v3;
    logic [WIDTH-1:0] s3;
    logic             cout3, ovf3, zero3;

    assign adv      = ~v3 | out_ready;
    assign in_ready = adv;

    // Bitwise generate/propagate/half-sum; the carry-in is folded into bit 0's
    // generate so the prefix network needs no separate carry input.
    logic [WIDTH-1:0] g0, p0, h0;
    always_comb begin
        h0    = x1 ^ y1;
        g0    = x1 & y1;
        p0    = x1 | y1;
        g0[0] = (x1[0] & y1[0]) | (p0[0] & c1);
    end

    // Up-sweep: level l combines pairs at span 2^l with black cells.
    for (genvar l = 0; l <= LVL; l++) begin : up
        logic [WIDTH-1:0] g, p;
        if (l == 0) begin : leaf
            assign g = g0;
            assign p = p0;
        end else begin : lvl
            for (genvar i = 0; i < WIDTH; i++) begin : node
                if ((i + 1) % (1 << l) == 0) begin : black
                    assign g[i] = up[l-1].g[i] | (up[l-1].p[i] & up[l-1].g[i - (1 << (l - 1))]);
                    assign p[i] = up[l-1].p[i] & up[l-1].p[i - (1 << (l - 1))];
                end else begin : pass
                    assign g[i] = up[l-1].g[i];
                    assign p[i] = up[l-1].p[i];
                end
            end
        end
    end

    // Down-sweep: step k works at group size 2^(LVL-k) and fills node
    // i = m*2^d + 2^(d-1) - 1 from the complete prefix just below its group.
    // Only group generates are needed here, so these are grey cells.
    for (genvar k = 0; k < LVL; k++) begin : dn
        logic [WIDTH-1:0] g;
        if (k == 0) begin : top
            assign g = g2;
        end else begin : lvl
            localparam int unsigned SPAN = 1 << (LVL - k - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : node
                if (i >= 2 * SPAN && (i + 1) % (2 * SPAN) == SPAN) begin : grey
                    assign g[i] = dn[k-1].g[i] | (p2[i] & dn[k-1].g[i - SPAN]);
                end else begin : pass
                    assign g[i] = dn[k-1].g[i];
                end
            end
        end
    end

    // gfull[i] = G[i:0], the carry out of bit i.
    logic [WIDTH-1:0] gfull;
    assign gfull = dn[LVL-1].g;

    // Propagates of groups that already reach bit 0 are never consulted.
    logic unused_prop;
    assign unused_prop = ^p2;

    logic [WIDTH-1:0] s_next;
    always_comb begin
        s_next            = h2;
        s_next[0]         = h2[0] ^ c2;
        s_next[WIDTH-1:1] = h2[WIDTH-1:1] ^ gfull[WIDTH-2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            x1    <= '0;
            y1    <= '0;
            c1    <= 1'b0;
            v2    <= 1'b0;
            h2    <= '0;
            g2    <= '0;
            p2    <= '0;
            c2    <= 1'b0;
            v3    <= 1'b0;
            s3    <= '0;
            cout3 <= 1'b0;
            ovf3  <= 1'b0;
            zero3 <= 1'b0;
        end else if (adv) begin
            v1    <= in_valid;
            x1    <= X;
            y1    <= sub ? ~Y : Y;
            c1    <= sub ? ~cin : cin;
            v2    <= v1;
            h2    <= h0;
            g2    <= up[LVL].g;
            p2    <= up[LVL].p;
            c2    <= c1;
            v3    <= v2;
            s3    <= s_next;
            cout3 <= gfull[WIDTH-1];
            ovf3  <= gfull[WIDTH-1] ^ gfull[WIDTH-2];
            zero3 <= ~|s_next;
        end
    end

    assign out_valid = v3;
    assign S         = s3;
    assign cout      = cout3;
    assign ovf       = ovf3;
    assign zero      = zero3;

endmodule
